// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
//   Round-robin write arbiter that owns the inputs of a shared parallel-load
//   register (load enable, data, synchronous clear). Requesters raise a level
//   request and hold it until they get their one-cycle ack. A clear request
//   is served before any write. Every output is registered.
//
//   Ports
//     clk      system clock, rising edge
//     clr_n    synchronous active-low reset
//     req      per-requester write request, level, held until ack
//     data     requester k data at [k*WIDTH +: WIDTH]
//     clr_req  clear request, level, held until clr_ack
//     lock     (ARB_LOCK_EN only) keep the pointer on the winner after its ack
//     load     register load enable
//     I        register parallel data
//     reg_clr  register clear, active high
//     gnt      one-hot current grant, zero when idle
//     ack      one-cycle completion pulse to the winner
//     clr_ack  one-cycle completion pulse for clr_req
//     busy     high whenever the FSM is not IDLE
//
//   Build option
//     ARB_LOCK_EN  adds the lock input for back-to-back burst ownership.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | arbitrate: clr_req first, otherwise round-robin from ptr
//   LOAD  | load=1, register captures I at the end of this cycle
//   ACK   | ack to the winner, pointer moves past it (or stays if locked)
//   CLEAR | reg_clr=1 and clr_ack=1 for one cycle, pointer untouched
module shared_reg_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  input  logic                  clr_req,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  output logic                  load,
  output logic [WIDTH-1:0]      I,
  output logic                  reg_clr,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  clr_ack,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, ACK, CLEAR} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [IW-1:0]   gidx, gidx_nxt;
  logic [IW-1:0]   win;
  logic            found;
  logic [CW-1:0]   cand;

  logic            load_nxt, reg_clr_nxt, clr_ack_nxt;
  logic [WIDTH-1:0] i_nxt;
  logic [NREQ-1:0] gnt_nxt, ack_nxt;

  // Rotating priority search: first asserted request at ptr, ptr+1, ... wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + CW'(i);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    gidx_nxt    = gidx;
    gnt_nxt     = gnt;
    i_nxt       = I;
    load_nxt    = 1'b0;
    reg_clr_nxt = 1'b0;
    clr_ack_nxt = 1'b0;
    ack_nxt     = '0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          reg_clr_nxt = 1'b1;
          clr_ack_nxt = 1'b1;
        end else if (found) begin
          state_nxt     = LOAD;
          gidx_nxt      = win;
          gnt_nxt       = '0;
          gnt_nxt[win]  = 1'b1;
          i_nxt         = data[int'(win)*WIDTH +: WIDTH];
          load_nxt      = 1'b1;
        end
      end
      LOAD: begin
        state_nxt = ACK;
        ack_nxt   = gnt;
      end
      ACK: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        if (gidx == IW'(NREQ - 1)) ptr_nxt = '0;
        else                       ptr_nxt = gidx + IW'(1);
`ifdef ARB_LOCK_EN
        // A locked winner keeps top priority for its next request.
        if (lock[gidx]) ptr_nxt = gidx;
`endif
      end
      CLEAR: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state   <= IDLE;
      ptr     <= '0;
      gidx    <= '0;
      gnt     <= '0;
      I       <= '0;
      load    <= 1'b0;
      reg_clr <= 1'b0;
      ack     <= '0;
      clr_ack <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gidx    <= gidx_nxt;
      gnt     <= gnt_nxt;
      I       <= i_nxt;
      load    <= load_nxt;
      reg_clr <= reg_clr_nxt;
      ack     <= ack_nxt;
      clr_ack <= clr_ack_nxt;
      busy    <= (state_nxt != IDLE);
    end
  end

endmodule
